// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, ExcCode values and write masks.
package cp0_reg_pkg;

  localparam logic        Valid     = 1'b1;
  localparam logic        Invalid   = 1'b0;
  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] Zero      = 32'h0000_0000;

  localparam logic [4:0] CP0_count   = 5'd9;
  localparam logic [4:0] CP0_compare = 5'd11;
  localparam logic [4:0] CP0_status  = 5'd12;
  localparam logic [4:0] CP0_cause   = 5'd13;
  localparam logic [4:0] CP0_epc     = 5'd14;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_TIMER   = 32'h0000_0004;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
  localparam logic [31:0] EXC_ERET    = 32'h0000_0200;

  localparam logic [4:0] EXCCODE_INT = 5'd0;
  localparam logic [4:0] EXCCODE_SYS = 5'd8;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam int CAUSE_TI   = 10;
  localparam int STATUS_EXL = 1;

  typedef enum logic [1:0] {
    EXC_KIND_NONE,
    EXC_KIND_TRAP,
    EXC_KIND_RET,
    EXC_KIND_OTHER
  } exc_kind_e;

  // Classifies the execute-stage exception code into the commit action it needs.
  function automatic exc_kind_e decode_exc(input logic [31:0] code);
    exc_kind_e kind;
    case (code)
      EXC_NONE:              kind = EXC_KIND_NONE;
      EXC_TIMER, EXC_SYSCALL: kind = EXC_KIND_TRAP;
      EXC_ERET:              kind = EXC_KIND_RET;
      default:               kind = EXC_KIND_OTHER;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/cp0_reg_timer.sv
// Count/Compare timer: free-running prescaler, Count, Compare and the match indication.
module cp0_timer
  import cp0_reg_pkg::*;
#(
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        match
);

  localparam logic [3:0] PRESCALE_LAST = 4'(COUNT_DIV - 1);

  logic [3:0]  prescale_q, prescale_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        inc_tick;

  // Next-state: prescaler wraps at COUNT_DIV-1, a Count write overrides that cycle's increment.
  always_comb begin
    inc_tick   = (prescale_q == PRESCALE_LAST);
    prescale_d = inc_tick ? 4'd0 : prescale_q + 4'd1;
    count_d    = count_q;
    compare_d  = compare_q;
    if (count_we) begin
      count_d = wdata;
    end else if (inc_tick) begin
      count_d = count_q + 32'd1;
    end
    if (compare_we) begin
      compare_d = wdata;
    end
    match = Invalid;
    if ((compare_q != Zero) && (count_q == compare_q)) begin
      match = Valid;
    end
  end

  // Timer state registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      prescale_q <= 4'd0;
      count_q    <= Zero;
      compare_q  <= Zero;
    end else begin
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: mfc0/mtc0 port, Status/Cause/EPC state and exception commit.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cp0we,
  input  logic [4:0]  cp0Addr,
  input  logic [31:0] cp0wData,
  output logic [31:0] cp0rData,
  input  logic [31:0] excptype,
  input  logic [31:0] pc,
  output logic [31:0] cause,
  output logic [31:0] status,
  output logic [31:0] epc,
  output logic        timer_int
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_w, compare_w;
  logic        match_w;
  logic        mtc0_en;
  logic        count_we, compare_we;
  exc_kind_e   exc_kind;

  // Any nonzero exception code takes the cycle, so an mtc0 alongside it is dropped.
  always_comb begin
    exc_kind   = decode_exc(excptype);
    mtc0_en    = (cp0we == Valid) && (excptype == EXC_NONE);
    count_we   = mtc0_en && (cp0Addr == CP0_count);
    compare_we = mtc0_en && (cp0Addr == CP0_compare);
  end

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (cp0wData),
    .count      (count_w),
    .compare    (compare_w),
    .match      (match_w)
  );

  // Next-state for Status/Cause/EPC: mtc0 writes, then exception commit, then timer bit.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;

    if (mtc0_en) begin
      case (cp0Addr)
        CP0_status: status_d = cp0wData & STATUS_WMASK;
        CP0_cause:  cause_d  = (cause_q & ~CAUSE_WMASK) | (cp0wData & CAUSE_WMASK);
        CP0_epc:    epc_d    = cp0wData;
        default:    ;
      endcase
    end

    case (exc_kind)
      EXC_KIND_TRAP: begin
        epc_d               = pc;
        status_d[STATUS_EXL] = 1'b1;
        cause_d[6:2]        = (excptype == EXC_TIMER) ? EXCCODE_INT : EXCCODE_SYS;
      end
      EXC_KIND_RET: begin
        status_d[STATUS_EXL] = 1'b0;
      end
      default: ;
    endcase

    if (match_w) begin
      cause_d[CAUSE_TI] = 1'b1;
    end
    if (compare_we) begin
      cause_d[CAUSE_TI] = 1'b0;
    end
  end

  // Status/Cause/EPC registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      status_q <= Zero;
      cause_q  <= Zero;
      epc_q    <= Zero;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // Combinational mfc0 read; unmapped addresses return zero.
  always_comb begin
    case (cp0Addr)
      CP0_count:   cp0rData = count_w;
      CP0_compare: cp0rData = compare_w;
      CP0_status:  cp0rData = status_q;
      CP0_cause:   cp0rData = cause_q;
      CP0_epc:     cp0rData = epc_q;
      default:     cp0rData = Zero;
    endcase
  end

  assign cause     = cause_q;
  assign status    = status_q;
  assign epc       = epc_q;
  assign timer_int = cause_q[CAUSE_TI];

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: vector table plus timer, wrap, reset and prescaler sequences.
module tb_cp0_reg;

  logic        clk;
  logic        rst;
  logic        cp0we;
  logic [4:0]  cp0Addr;
  logic [31:0] cp0wData;
  logic [31:0] excptype;
  logic [31:0] pc;
  logic [31:0] cp0rData, cause, status, epc;
  logic        timer_int;
  logic [31:0] cp0rData4, cause4, status4, epc4;
  logic        timer_int4;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exc;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [31:0] exp_rdata;
    logic [31:0] exp_cause;
    logic [31:0] exp_status;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[14];

  cp0_reg #(.COUNT_DIV(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cp0we     (cp0we),
    .cp0Addr   (cp0Addr),
    .cp0wData  (cp0wData),
    .cp0rData  (cp0rData),
    .excptype  (excptype),
    .pc        (pc),
    .cause     (cause),
    .status    (status),
    .epc       (epc),
    .timer_int (timer_int)
  );

  cp0_reg #(.COUNT_DIV(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .cp0we     (cp0we),
    .cp0Addr   (cp0Addr),
    .cp0wData  (cp0wData),
    .cp0rData  (cp0rData4),
    .excptype  (excptype),
    .pc        (pc),
    .cause     (cause4),
    .status    (status4),
    .epc       (epc4),
    .timer_int (timer_int4)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exc, input logic [31:0] pc_in);
    cp0we    = we;
    cp0Addr  = addr;
    cp0wData = wdata;
    excptype = exc;
    pc       = pc_in;
    tick(1);
    cp0we    = 1'b0;
    cp0wData = 32'h0;
    excptype = 32'h0;
    pc       = 32'h0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkRead(input string name, input logic [4:0] addr, input logic [31:0] expected);
    cp0Addr = addr;
    #1;
    checkOutput(name, cp0rData, expected);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    tests_run    = 0;
    tests_failed = 0;
    cp0we    = 1'b0;
    cp0Addr  = 5'd0;
    cp0wData = 32'h0;
    excptype = 32'h0;
    pc       = 32'h0;

    vecs[0]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0,   32'h0,   5'd12, 32'h0000_FF03, 32'h000, 32'hFF03, 32'h0};
    vecs[1]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0,   32'h0,   5'd13, 32'h0000_0300, 32'h300, 32'hFF03, 32'h0};
    vecs[2]  = '{1'b1, 5'd14, 32'h1234_5678, 32'h0,   32'h0,   5'd14, 32'h1234_5678, 32'h300, 32'hFF03, 32'h1234_5678};
    vecs[3]  = '{1'b1, 5'd5,  32'h0000_AAAA, 32'h0,   32'h0,   5'd5,  32'h0,         32'h300, 32'hFF03, 32'h1234_5678};
    vecs[4]  = '{1'b1, 5'd11, 32'hFFFF_0000, 32'h0,   32'h0,   5'd11, 32'hFFFF_0000, 32'h300, 32'hFF03, 32'h1234_5678};
    vecs[5]  = '{1'b1, 5'd12, 32'h0,         32'h0,   32'h0,   5'd12, 32'h0,         32'h300, 32'h0,    32'h1234_5678};
    vecs[6]  = '{1'b1, 5'd13, 32'h0000_0100, 32'h0,   32'h0,   5'd13, 32'h0000_0100, 32'h100, 32'h0,    32'h1234_5678};
    vecs[7]  = '{1'b1, 5'd14, 32'h0000_DEAD, 32'h100, 32'h80,  5'd14, 32'h0000_0080, 32'h120, 32'h2,    32'h80};
    vecs[8]  = '{1'b1, 5'd12, 32'h0000_FFFF, 32'h200, 32'h0,   5'd12, 32'h0,         32'h120, 32'h0,    32'h80};
    vecs[9]  = '{1'b1, 5'd14, 32'h0000_5555, 32'h8,   32'h0,   5'd14, 32'h0000_0080, 32'h120, 32'h0,    32'h80};
    vecs[10] = '{1'b1, 5'd12, 32'h0000_0401, 32'h0,   32'h0,   5'd12, 32'h0000_0401, 32'h120, 32'h401,  32'h80};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         32'h4,   32'h120, 5'd13, 32'h0000_0100, 32'h100, 32'h403,  32'h120};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         32'h200, 32'h0,   5'd14, 32'h0000_0120, 32'h100, 32'h401,  32'h120};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         32'h0,   32'h0,   5'd31, 32'h0,         32'h100, 32'h401,  32'h120};

    // Reset state and free-running Count
    rst = 1'b1;
    #1;
    checkOutput("reset cause", cause, 32'h0);
    checkOutput("reset status", status, 32'h0);
    checkOutput("reset epc", epc, 32'h0);
    checkOutput("reset timer_int", {31'b0, timer_int}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(10);
    checkRead("count after 10 clocks", 5'd9, 32'h0000_000A);
    checkOutput("div4 count after 10 clocks", cp0rData4, 32'h2);

    // Reset asserted in the middle of a write and an exception
    cp0we    = 1'b1;
    cp0Addr  = 5'd12;
    cp0wData = 32'hFFFF_FFFF;
    excptype = 32'h100;
    pc       = 32'h44;
    rst      = 1'b1;
    #1;
    checkOutput("mid-run reset rdata", cp0rData, 32'h0);
    checkOutput("mid-run reset status", status, 32'h0);
    checkOutput("mid-run reset epc", epc, 32'h0);
    tick(1);
    checkOutput("held reset status", status, 32'h0);
    checkOutput("held reset epc", epc, 32'h0);
    cp0we    = 1'b0;
    cp0wData = 32'h0;
    excptype = 32'h0;
    pc       = 32'h0;
    checkRead("held reset count", 5'd9, 32'h0);
    tick(1);
    rst = 1'b0;

    // Timer match raises cause[10] on the edge after Count == Compare
    applyStimulus(1'b1, 5'd11, 32'h0000_0014, 32'h0, 32'h0);
    applyStimulus(1'b1, 5'd12, 32'h0000_0401, 32'h0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (timer_int) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("timer_int rises", {31'b0, found}, 32'h1);
    checkRead("count when timer_int rises", 5'd9, 32'h0000_0015);
    checkOutput("status after mtc0", status, 32'h0000_0401);
    tick(3);
    checkOutput("timer_int sticky", {31'b0, timer_int}, 32'h1);
    checkOutput("cause timer bit sticky", cause, 32'h0000_0400);
    applyStimulus(1'b1, 5'd11, 32'h0000_0040, 32'h0, 32'h0);
    checkOutput("compare write clears timer_int", {31'b0, timer_int}, 32'h0);

    // Match and Compare write in the same cycle: the clear wins
    cp0Addr = 5'd9;
    #1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cp0rData == 32'h0000_0040) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    checkOutput("count reaches 0x40", {31'b0, found}, 32'h1);
    applyStimulus(1'b1, 5'd11, 32'h0000_0040, 32'h0, 32'h0);
    checkOutput("set/clear same cycle", {31'b0, timer_int}, 32'h0);
    tick(1);
    checkOutput("no match after collision", {31'b0, timer_int}, 32'h0);

    // Count write overrides increment, then wraps to zero
    applyStimulus(1'b1, 5'd9, 32'hFFFF_FFFF, 32'h0, 32'h0);
    checkRead("count loaded", 5'd9, 32'hFFFF_FFFF);
    tick(1);
    checkRead("count wraps", 5'd9, 32'h0);

    // Vector table: masking, unmapped addresses, exception priority and commit
    resetDut();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exc, vecs[i].pc);
      checkRead($sformatf("vec%0d rdata", i), vecs[i].rd_addr, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d cause", i), cause, vecs[i].exp_cause);
      checkOutput($sformatf("vec%0d status", i), status, vecs[i].exp_status);
      checkOutput($sformatf("vec%0d epc", i), epc, vecs[i].exp_epc);
      checkOutput($sformatf("vec%0d timer_int", i), {31'b0, timer_int}, 32'h0);
    end

    // Prescaled Count and a Count write landing on the increment phase
    resetDut();
    tick(3);
    cp0Addr = 5'd9;
    #1;
    checkOutput("div4 count edge3", cp0rData4, 32'h0);
    tick(1);
    checkOutput("div4 count edge4", cp0rData4, 32'h1);
    tick(4);
    checkOutput("div4 count edge8", cp0rData4, 32'h2);
    tick(3);
    checkOutput("div4 count edge11", cp0rData4, 32'h2);
    applyStimulus(1'b1, 5'd9, 32'h0000_0100, 32'h0, 32'h0);
    checkOutput("div4 count write", cp0rData4, 32'h0000_0100);
    checkOutput("div1 count write", cp0rData, 32'h0000_0100);
    tick(3);
    checkOutput("div4 count holds", cp0rData4, 32'h0000_0100);
    tick(1);
    checkOutput("div4 count after write", cp0rData4, 32'h0000_0101);
    checkOutput("div1 count after write", cp0rData, 32'h0000_0104);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
